// File: rtl/debugger_pkg.sv
// Shared types and constants for the on-chip debugger capture path.
package debugger_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    WAIT = 3'd2,
    POST = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic TRIG_AND = 1'b0;
  localparam logic TRIG_OR  = 1'b1;

endpackage

// File: rtl/capture_ctrl_trig_combine.sv
// Reduces the per-channel trigger vector to a single hit using the channel
// mask and the AND/OR combine mode.
module trig_combine
  import debugger_pkg::*;
#(
  parameter int PORT_WIDTH = 32
) (
  input  logic                  i_trig_or,
  input  logic [PORT_WIDTH-1:0] i_trig_en,
  input  logic [PORT_WIDTH-1:0] i_ch_mask,
  output logic                  o_hit
);

  logic w_any;
  logic w_all;

  // Masked-off channels count as 1 for AND so an empty mask always hits.
  assign w_any = |(i_trig_en & i_ch_mask);
  assign w_all = &(i_trig_en | ~i_ch_mask);
  assign o_hit = (i_trig_or == TRIG_OR) ? w_any : w_all;

endmodule

// File: rtl/capture_ctrl.sv
// Capture controller: combines channel triggers, streams delayed probe samples
// into a circular sample RAM and reports the trigger/oldest-sample addresses.
module capture_ctrl
  import debugger_pkg::*;
#(
  parameter int PORT_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  trig_or,
  input  logic [PORT_WIDTH-1:0] ch_mask,
  input  logic [ADDR_WIDTH-1:0] pre_depth,
  input  logic [PORT_WIDTH-1:0] testport,
  input  logic [PORT_WIDTH-1:0] trig_en,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [PORT_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic [ADDR_WIDTH-1:0] start_addr
);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0] r_pre_cnt;
  logic [ADDR_WIDTH-1:0] r_post_cnt;
  logic [ADDR_WIDTH-1:0] r_cfg_pre;
  logic                  r_cfg_or;
  logic [PORT_WIDTH-1:0] r_cfg_mask;
  logic [PORT_WIDTH-1:0] r_data_d;

  logic                  w_hit;
  logic                  w_writing;
  logic [ADDR_WIDTH-1:0] w_post_init;
  logic [ADDR_WIDTH-1:0] w_pre_last;

  trig_combine #(
    .PORT_WIDTH(PORT_WIDTH)
  ) u_trig_combine (
    .i_trig_or(r_cfg_or),
    .i_trig_en(trig_en),
    .i_ch_mask(r_cfg_mask),
    .o_hit    (w_hit)
  );

  assign w_writing   = (r_state == PRE) || (r_state == WAIT) || (r_state == POST);
  // DEPTH-1-pre_depth is the bitwise complement within ADDR_WIDTH bits.
  assign w_post_init = ~r_cfg_pre;
  assign w_pre_last  = r_cfg_pre - ADDR_WIDTH'(1);

  // Probe data is delayed one cycle so level triggers align with their sample.
  always_ff @(posedge clk) begin
    r_data_d <= testport;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_pre_cnt  <= '0;
      r_post_cnt <= '0;
      r_cfg_pre  <= '0;
      r_cfg_or   <= TRIG_AND;
      r_cfg_mask <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      trig_addr  <= '0;
      start_addr <= '0;
    end else if (abort) begin
      r_state <= IDLE;
      wr_en   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      wr_en <= w_writing;
      busy  <= w_writing;
      if (w_writing) begin
        wr_addr <= r_ptr;
        wr_data <= r_data_d;
        r_ptr   <= r_ptr + ADDR_WIDTH'(1);
      end

      case (r_state)
        IDLE, DONE: begin
          if (r_state == DONE) begin
            done       <= 1'b1;
            start_addr <= trig_addr - r_cfg_pre;
          end
          if (arm) begin
            r_cfg_or   <= trig_or;
            r_cfg_mask <= ch_mask;
            r_cfg_pre  <= pre_depth;
            r_ptr      <= '0;
            r_pre_cnt  <= '0;
            done       <= 1'b0;
            r_state    <= (pre_depth == '0) ? WAIT : PRE;
          end
        end
        PRE: begin
          r_pre_cnt <= r_pre_cnt + ADDR_WIDTH'(1);
          if (r_pre_cnt == w_pre_last) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (w_hit) begin
            trig_addr  <= r_ptr;
            r_post_cnt <= w_post_init;
            r_state    <= (w_post_init == '0) ? DONE : POST;
          end
        end
        POST: begin
          r_post_cnt <= r_post_cnt - ADDR_WIDTH'(1);
          if (r_post_cnt == ADDR_WIDTH'(1)) begin
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with ADDR_WIDTH=4, PORT_WIDTH=8.
module tb_capture_ctrl;
  import debugger_pkg::*;

  localparam int PW = 8;
  localparam int AW = 4;

  logic          clk;
  logic          rstn;
  logic          arm;
  logic          abort;
  logic          trig_or;
  logic [PW-1:0] ch_mask;
  logic [AW-1:0] pre_depth;
  logic [PW-1:0] testport;
  logic [PW-1:0] trig_en;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] trig_addr;
  logic [AW-1:0] start_addr;

  int checks = 0;
  int errors = 0;
  int nwr;

  capture_ctrl #(
    .PORT_WIDTH(PW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .arm       (arm),
    .abort     (abort),
    .trig_or   (trig_or),
    .ch_mask   (ch_mask),
    .pre_depth (pre_depth),
    .testport  (testport),
    .trig_en   (trig_en),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .trig_addr (trig_addr),
    .start_addr(start_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn      = 1'b0;
    arm       = 1'b0;
    abort     = 1'b0;
    trig_or   = TRIG_AND;
    ch_mask   = '0;
    pre_depth = '0;
    testport  = '0;
    trig_en   = '0;
    step();
    step();
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_trig_addr", 32'(trig_addr), 0);
    chk("rst_start_addr", 32'(start_addr), 0);
    rstn = 1'b1;
    step();

    // Scenario 1: AND mask 03, pre 4, trigger on 7th write.
    trig_or = TRIG_AND; ch_mask = 8'h03; pre_depth = 4'd4; testport = 8'h5A;
    arm = 1'b1;
    step();
    arm = 1'b0;
    ch_mask = 8'hFF; pre_depth = 4'd9; trig_or = TRIG_OR;
    step();
    chk("s1_first_wr_en", 32'(wr_en), 1);
    chk("s1_first_wr_addr", 32'(wr_addr), 0);
    chk("s1_first_busy", 32'(busy), 1);
    chk("s1_wr_data_const", 32'(wr_data), 32'h5A);
    testport = 8'h11;
    step();
    testport = 8'h22;
    step();
    chk("s1_wr_data_delay", 32'(wr_data), 32'h11);
    chk("s1_addr2", 32'(wr_addr), 2);
    step();
    step();
    trig_en = 8'h01;
    step();
    chk("s1_no_partial_hit_addr", 32'(wr_addr), 5);
    trig_en = 8'h03;
    step();
    trig_en = 8'h00;
    chk("s1_hit_wr_addr", 32'(wr_addr), 6);
    chk("s1_trig_addr", 32'(trig_addr), 6);
    repeat (11) step();
    chk("s1_last_post_addr", 32'(wr_addr), 1);
    chk("s1_last_post_wr_en", 32'(wr_en), 1);
    chk("s1_last_post_done", 32'(done), 0);
    step();
    chk("s1_end_wr_en", 32'(wr_en), 0);
    chk("s1_end_busy", 32'(busy), 0);
    chk("s1_end_done", 32'(done), 1);
    chk("s1_start_addr", 32'(start_addr), 2);
    step();
    chk("s1_done_sticky", 32'(done), 1);

    // Scenario 2: OR mask 80, pre 3; PRE pulse ignored, WAIT pulse triggers.
    trig_or = TRIG_OR; ch_mask = 8'h80; pre_depth = 4'd3;
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk("s2_done_cleared", 32'(done), 0);
    trig_en = 8'h80;
    step();
    trig_en = 8'h00;
    step();
    step();
    trig_en = 8'h7F;
    step();
    trig_en = 8'h00;
    step();
    chk("s2_no_early_trig", 32'(trig_addr), 6);
    trig_en = 8'h80;
    step();
    trig_en = 8'h00;
    chk("s2_trig_addr", 32'(trig_addr), 5);
    repeat (12) step();
    chk("s2_last_post_addr", 32'(wr_addr), 1);
    step();
    chk("s2_done", 32'(done), 1);
    chk("s2_start_addr", 32'(start_addr), 2);

    // Scenario 3: pre 0 with empty AND mask, hit every cycle.
    trig_or = TRIG_AND; ch_mask = 8'h00; pre_depth = 4'd0;
    arm = 1'b1;
    step();
    arm = 1'b0;
    step();
    chk("s3_trig_addr", 32'(trig_addr), 0);
    chk("s3_first_addr", 32'(wr_addr), 0);
    nwr = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (wr_en) nwr++;
      if (done) break;
    end
    chk("s3_done_in_time", 32'(done), 1);
    chk("s3_write_count", 32'(nwr), 16);
    chk("s3_last_addr", 32'(wr_addr), 15);
    chk("s3_start_addr", 32'(start_addr), 0);

    // Scenario 4: pre 15 leaves no post window.
    trig_or = TRIG_OR; ch_mask = 8'h01; pre_depth = 4'd15; trig_en = 8'h01;
    arm = 1'b1;
    step();
    arm = 1'b0;
    repeat (15) step();
    chk("s4_pre_last_addr", 32'(wr_addr), 14);
    chk("s4_pre_no_trig", 32'(trig_addr), 0);
    step();
    trig_en = 8'h00;
    chk("s4_trig_addr", 32'(trig_addr), 15);
    step();
    chk("s4_wr_en_off", 32'(wr_en), 0);
    chk("s4_done", 32'(done), 1);
    chk("s4_start_addr", 32'(start_addr), 0);

    // Scenario 5: long WAIT wraps the pointer; arm mid-capture ignored.
    trig_or = TRIG_OR; ch_mask = 8'h02; pre_depth = 4'd2; trig_en = 8'h00;
    testport = 8'hC3;
    arm = 1'b1;
    step();
    arm = 1'b0;
    step();
    step();
    for (int i = 0; i < 25; i++) begin
      arm = (i == 12);
      step();
    end
    arm = 1'b0;
    chk("s5_wrapped_addr", 32'(wr_addr), 10);
    chk("s5_wr_data", 32'(wr_data), 32'hC3);
    chk("s5_busy", 32'(busy), 1);
    trig_en = 8'h02;
    step();
    trig_en = 8'h00;
    chk("s5_trig_addr", 32'(trig_addr), 11);
    repeat (13) step();
    chk("s5_last_post_addr", 32'(wr_addr), 8);
    step();
    chk("s5_done", 32'(done), 1);
    chk("s5_start_addr", 32'(start_addr), 9);

    // Scenario 6: abort beats hit and arm, then restart and reset mid-POST.
    trig_or = TRIG_AND; ch_mask = 8'h01; pre_depth = 4'd1; trig_en = 8'h00;
    arm = 1'b1;
    step();
    arm = 1'b0;
    step();
    step();
    chk("s6_wait_addr", 32'(wr_addr), 1);
    trig_en = 8'h01; arm = 1'b1; abort = 1'b1;
    step();
    trig_en = 8'h00; arm = 1'b0; abort = 1'b0;
    step();
    chk("s6_abort_wr_en", 32'(wr_en), 0);
    chk("s6_abort_busy", 32'(busy), 0);
    chk("s6_abort_done", 32'(done), 0);
    chk("s6_abort_trig_addr", 32'(trig_addr), 11);
    ch_mask = 8'h00; pre_depth = 4'd5; testport = 8'h77;
    arm = 1'b1;
    step();
    arm = 1'b0;
    step();
    chk("s6_restart_wr_en", 32'(wr_en), 1);
    chk("s6_restart_addr", 32'(wr_addr), 0);
    repeat (5) step();
    chk("s6_trig_addr", 32'(trig_addr), 5);
    repeat (3) step();
    chk("s6_post_busy", 32'(busy), 1);
    rstn = 1'b0;
    step();
    chk("s6_rst_wr_en", 32'(wr_en), 0);
    chk("s6_rst_wr_addr", 32'(wr_addr), 0);
    chk("s6_rst_wr_data", 32'(wr_data), 0);
    chk("s6_rst_busy", 32'(busy), 0);
    chk("s6_rst_done", 32'(done), 0);
    chk("s6_rst_trig_addr", 32'(trig_addr), 0);
    chk("s6_rst_start_addr", 32'(start_addr), 0);
    rstn = 1'b1;
    step();
    chk("s6_idle_after_rst", 32'(wr_en), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
